program_loader: RTL
===================

Name: program_loader

Overview:
- Write-side counterpart of the instruction memory's read port: receives a program as a byte stream (valid/ready) and writes it into instruction memory, one 32-bit word per write.
- Holds the CPU in reset (cpu_hold) while loading. Releases the hold once the last word is committed.
- Sits between the host/UART byte receiver and the instruction memory's write port.

Parameters:
- MEM_SIZE, 128, instruction memory depth in 32-bit words; maximum loadable word count.
- CNT_W, $clog2(MEM_SIZE+1), width of the word counters.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a byte is offered on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at the clock edge.
- load_req  in  1  single-cycle pulse; restarts loading from S_DONE only.
- mem_we  out  1  write strobe to instruction memory, one cycle per word.
- mem_addr  out  32  byte address of the write, word aligned (bits [1:0] = 0).
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  hold/reset request to the core.
- done  out  1  load completed successfully.
- error  out  1  rejected load: length > MEM_SIZE.
- words_loaded  out  CNT_W  number of words committed in the current load.

Behaviour:
- Stream format:
  - A 4-byte little-endian word count N comes first.
  - Then N words follow, each 4 bytes little-endian. The first byte received maps to bits [7:0].
- Reset values:
  - state = S_LEN, in_ready = 1, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_hold = 1, done = 0, error = 0, words_loaded = 0.
  - The byte counter and assembly register are cleared.
- States:
  - S_LEN: in_ready = 1. Assemble 4 bytes into N.
    - On the 4th accepted byte: if N == 0, go to S_DONE; if N > MEM_SIZE, go to S_ERR; otherwise go to S_DATA.
  - S_DATA: in_ready = 1. Assemble 4 bytes.
    - On the 4th accepted byte, latch mem_wdata (the full word) and mem_addr = words_loaded*4, then go to S_WRITE.
  - S_WRITE: exactly one cycle.
    - mem_we = 1, in_ready = 0; words_loaded increments at the end of this cycle.
    - If words_loaded+1 == N, go to S_DONE; otherwise go to S_DATA.
  - S_DONE: cpu_hold = 0, done = 1, in_ready = 0. Bytes offered here are not consumed.
    - load_req: go to S_LEN with the counters cleared, cpu_hold = 1, done = 0.
  - S_ERR: cpu_hold = 1, error = 1, in_ready = 0. Sticky until rst; load_req is ignored.
- Latency: the write strobe is asserted in the cycle after the 4th byte of a word is accepted.
  - Minimum of 5 cycles per word.
  - Back-to-back in_valid is allowed; in_ready drops for the S_WRITE cycle only.
- mem_addr and mem_wdata hold their last values outside S_WRITE. mem_we is 0 outside S_WRITE.
- cpu_hold falls in the same cycle done rises; the first cycle of S_DONE registers both.
- Boundaries:
  - in_valid low mid-word: the partial assembly is retained indefinitely (no timeout).
  - N == MEM_SIZE: the last write goes to address (MEM_SIZE-1)*4 and there is no error.
  - rst mid-load: synchronous return to the reset values. Words already written stay in memory.
  - load_req outside S_DONE has no effect.
- Arithmetic:
  - The length register is 32 bits; the comparison against MEM_SIZE is unsigned over the full 32 bits.
  - words_loaded never exceeds MEM_SIZE.

Decomposition:
- Shared package (riscv_pkg): loader_state_t enum {S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} and the constant WORD_BYTES = 4.
- One natural sub-module: byte_to_word_assembler.
  - Ports: clk, rst, clear, byte_valid, byte_in[7:0], word_out[31:0], word_valid (pulse on the 4th byte).
  - Contains the 2-bit byte counter and the shift register; it is reused for both the length field and the data words.

Test Plan:
- Reset then stream 02 00 00 00, 13 00 50 00, 93 00 A0 00 -> mem_we pulses twice: addr 0x0 data 0x00500013, then addr 0x4 data 0x00A00093. Then done = 1, cpu_hold = 0, words_loaded = 2.
- Length 00 00 00 00 -> S_DONE directly, no mem_we, done = 1 one cycle after the 4th byte.
- Length 81 00 00 00 (129 > 128) -> error = 1, cpu_hold = 1, in_ready = 0. A load_req pulse leaves error = 1; only rst clears it.
- Length 01 00 00 00, then 2 data bytes, in_valid held low for 10 cycles, then 2 more bytes (EF BE AD DE total) -> single write of 0xDEADBEEF at addr 0x0 with no spurious mem_we during the gap.
- After a completed 1-word load: load_req, then a new 1-word stream 78 56 34 12 -> cpu_hold reasserts the cycle after load_req, writes 0x12345678 at addr 0x0, words_loaded = 1.
- Assert rst while 3 data words of a 4-word load are written -> all outputs return to reset values the next cycle. A fresh stream loads correctly from addr 0x0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the program loader.
//   loader_state_t : states of the loader FSM
//   WORD_BYTES     : bytes per instruction word on the byte stream
//   word_byte_addr : converts a word index into a word-aligned byte address
package riscv_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } loader_state_t;

    function automatic logic [31:0] word_byte_addr(input logic [31:0] idx);
        return idx << $clog2(WORD_BYTES);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Signal bundle between the byte source / instruction memory / core and the
// program loader.
//   in_valid, in_data, in_ready : byte stream (valid/ready)
//   load_req                    : restart request (acted on only when done)
//   mem_we, mem_addr, mem_wdata : instruction memory write port
//   cpu_hold, done, error       : load status towards the core
//   words_loaded                : words committed in the current load
// slave  = the loader, master = everything around it.
interface program_loader_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             load_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             cpu_hold;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] words_loaded;

    modport master (
        output in_valid, in_data, load_req,
        input  in_ready, mem_we, mem_addr, mem_wdata,
               cpu_hold, done, error, words_loaded
    );

    modport slave (
        input  in_valid, in_data, load_req,
        output in_ready, mem_we, mem_addr, mem_wdata,
               cpu_hold, done, error, words_loaded
    );
endinterface

// File: rtl/byte_to_word_assembler.sv
// Collects little-endian bytes into 32-bit words.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drop any partial word and restart at byte 0
//   byte_valid : byte_in is consumed this cycle
//   byte_in    : stream byte
//   word_out   : assembled word, meaningful while word_valid is high
//   word_valid : pulses in the cycle the 4th byte of a word is consumed
// Only the first three bytes are stored; the 4th is taken straight from
// byte_in so the word is available in the same cycle it completes.
module byte_to_word_assembler
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_valid
);

    logic [1:0]  byte_cnt_reg;
    logic [23:0] shift_reg;

    // Bytes enter at the top and move down, so the first byte of a word
    // ends up in bits [7:0].
    assign word_out   = {byte_in, shift_reg};
    assign word_valid = byte_valid && (byte_cnt_reg == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_cnt_reg <= '0;
            shift_reg    <= '0;
        end else if (byte_valid) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            shift_reg    <= {byte_in, shift_reg[23:8]};
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a program from a byte stream into instruction memory.
// Stream: 32-bit LE word count N, then N LE words. Each word is written
// once (mem_we one cycle) at byte address index*4. The core is held
// (cpu_hold) until the last word is committed; a length above MEM_SIZE
// parks the loader in a sticky error state until rst.
//   clk, rst : clock, synchronous active-high reset
//   bus      : program_loader_if slave (stream, memory write, status)
module program_loader
    import riscv_pkg::*;
#(
    parameter int MEM_SIZE = 128,
    parameter int CNT_W    = $clog2(MEM_SIZE + 1)
) (
    input  logic            clk,
    input  logic            rst,
    program_loader_if.slave bus
);

    loader_state_t    state_reg, state_next;
    logic [31:0]      len_reg, len_next;
    logic [CNT_W-1:0] words_reg, words_next;
    logic [31:0]      addr_reg, addr_next;
    logic [31:0]      wdata_reg, wdata_next;

    logic        ready_w;
    logic        byte_fire;
    logic        asm_clear;
    logic [31:0] asm_word;
    logic        asm_valid;

    assign ready_w   = (state_reg == S_LEN) || (state_reg == S_DATA);
    assign byte_fire = bus.in_valid && ready_w;

    byte_to_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (byte_fire),
        .byte_in    (bus.in_data),
        .word_out   (asm_word),
        .word_valid (asm_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_LEN;
            len_reg   <= '0;
            words_reg <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            words_reg <= words_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        words_next = words_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        asm_clear  = 1'b0;
        case (state_reg)
            S_LEN: begin
                if (asm_valid) begin
                    len_next = asm_word;
                    // Full 32-bit unsigned compare: a huge length must not
                    // alias onto a small one.
                    if (asm_word == 32'd0)
                        state_next = S_DONE;
                    else if (asm_word > 32'(MEM_SIZE))
                        state_next = S_ERR;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (asm_valid) begin
                    wdata_next = asm_word;
                    addr_next  = word_byte_addr(32'(words_reg));
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                words_next = words_reg + 1'b1;
                if (32'(words_reg) + 32'd1 == len_reg)
                    state_next = S_DONE;
                else
                    state_next = S_DATA;
            end
            S_DONE: begin
                if (bus.load_req) begin
                    state_next = S_LEN;
                    len_next   = '0;
                    words_next = '0;
                    asm_clear  = 1'b1;
                end
            end
            S_ERR: begin
                // Sticky until rst.
            end
            default: state_next = S_LEN;
        endcase
    end

    // All status outputs decode directly from the state register.
    assign bus.in_ready     = ready_w;
    assign bus.mem_we       = (state_reg == S_WRITE);
    assign bus.mem_addr     = addr_reg;
    assign bus.mem_wdata    = wdata_reg;
    assign bus.cpu_hold     = (state_reg != S_DONE);
    assign bus.done         = (state_reg == S_DONE);
    assign bus.error        = (state_reg == S_ERR);
    assign bus.words_loaded = words_reg;

endmodule
